// File: rtl/imem_serial_loader.sv
// Byte-stream loader for the instruction memory: reads a 16-bit word count, then
// assembles little-endian 32-bit words and issues one registered write per word.
module imem_serial_loader #(
  parameter int MEM_WORDS = 49
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] words_loaded,
  output logic [2:0]  dbg_state
);

  // Handshake: a byte moves on a rising edge where in_valid && in_ready are both 1;
  // in_valid may drop between bytes and in_data is only looked at during a transfer.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN0  = 3'd1,
    S_LEN1  = 3'd2,
    S_DATA  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_cnt;
  logic [31:0] r_word;
  logic [1:0]  r_byte_cnt;
  logic [15:0] r_word_idx;
  logic [15:0] r_words_loaded;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;

  logic        w_xfer;
  logic [15:0] w_count;
  logic        w_last_byte;
  logic        w_last_word;
  logic [31:0] w_word_full;

  assign w_xfer      = in_valid & in_ready;
  assign w_count     = {in_data, r_cnt[7:0]};
  assign w_last_byte = (r_byte_cnt == 2'd3);
  assign w_last_word = ((r_word_idx + 16'd1) == r_cnt);
  assign w_word_full = {in_data, r_word[31:8]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (start) w_next = S_LEN0;
      S_LEN0:  if (w_xfer) w_next = S_LEN1;
      S_LEN1: begin
        if (w_xfer) begin
          if (w_count == 16'd0)                   w_next = S_DONE;
          else if (w_count > 16'(MEM_WORDS))      w_next = S_ERR;
          else                                    w_next = S_DATA;
        end
      end
      S_DATA:  if (w_xfer && w_last_byte) w_next = S_WRITE;
      S_WRITE: w_next = w_last_word ? S_DONE : S_DATA;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (r_state)
      S_LEN0, S_LEN1, S_DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      S_WRITE: busy = 1'b1;
      S_DONE:  done = 1'b1;
      S_ERR:   err  = 1'b1;
      default: ;
    endcase
  end

  // Write address/data are captured with the 4th byte so they are stable for the whole WRITE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt          <= '0;
      r_word         <= '0;
      r_byte_cnt     <= '0;
      r_word_idx     <= '0;
      r_words_loaded <= '0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_cnt          <= '0;
            r_word         <= '0;
            r_byte_cnt     <= '0;
            r_word_idx     <= '0;
            r_words_loaded <= '0;
          end
        end
        S_LEN0: if (w_xfer) r_cnt[7:0]  <= in_data;
        S_LEN1: if (w_xfer) r_cnt[15:8] <= in_data;
        S_DATA: begin
          if (w_xfer) begin
            r_word     <= w_word_full;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (w_last_byte) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= {14'd0, r_word_idx, 2'b00};
              r_mem_wdata <= w_word_full;
            end
          end
        end
        S_WRITE: begin
          r_words_loaded <= r_words_loaded + 16'd1;
          // Index stays on the last legal word once the image is complete.
          if (!w_last_word) r_word_idx <= r_word_idx + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign words_loaded = r_words_loaded;
  assign dbg_state    = r_state;

endmodule
